// File: rtl/rom_word_sequencer.sv
// rtl/rom_word_sequencer.sv - ROM address sequencer feeding the 7-segment display (optional ROM_SEQ_PINGPONG_EN)
module rom_word_sequencer #(
    parameter int ADDR_W     = 4,
    parameter int DATA_W     = 16,
    parameter int ADDR_START = 0,
    parameter int ADDR_END   = 15,
    parameter int HOLD_TICKS = 1,
    parameter int ROM_LAT    = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tick,
    input  logic              run,
    input  logic              step,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_q,
    output logic [DATA_W-1:0] data,
    output logic              data_valid,
    output logic [ADDR_W-1:0] cur_addr,
    output logic              busy
);

    localparam int HC_W = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
    localparam int LC_W = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;

    localparam logic [ADDR_W-1:0] A_START   = ADDR_W'(ADDR_START);
    localparam logic [ADDR_W-1:0] A_END     = ADDR_W'(ADDR_END);
    localparam logic [HC_W-1:0]   HOLD_LAST = HC_W'(HOLD_TICKS - 1);
    localparam logic [LC_W-1:0]   LAT_LAST  = LC_W'(ROM_LAT - 1);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_LATCH = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t            state;
    state_t            state_next;
    logic              advance;
    logic [ADDR_W-1:0] addr_next;
    logic [HC_W-1:0]   hold_cnt;
    logic [LC_W-1:0]   lat_cnt;

`ifdef ROM_SEQ_PINGPONG_EN
    logic dir_desc;
    logic dir_desc_next;

    // Ping-pong address step: bounce off either end of the range.
    always_comb begin
        addr_next     = rom_addr + ADDR_W'(1);
        dir_desc_next = dir_desc;
        if (A_START == A_END) begin
            addr_next = rom_addr;
        end else if (!dir_desc) begin
            if (rom_addr == A_END) begin
                dir_desc_next = 1'b1;
                addr_next     = rom_addr - ADDR_W'(1);
            end
        end else begin
            if (rom_addr == A_START) begin
                dir_desc_next = 1'b0;
            end else begin
                addr_next = rom_addr - ADDR_W'(1);
            end
        end
    end

    // Direction only changes when the sequencer actually advances.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dir_desc <= 1'b0;
        end else if (advance) begin
            dir_desc <= dir_desc_next;
        end
    end
`else
    // Wrapping address step: last address of the range returns to the first.
    always_comb begin
        addr_next = rom_addr + ADDR_W'(1);
        if (rom_addr == A_END) begin
            addr_next = A_START;
        end
    end
`endif

    // Next-state logic; advance is only honoured while holding a word.
    always_comb begin
        state_next = state;
        advance    = 1'b0;
        case (state)
            S_FETCH: state_next = S_WAIT;
            S_WAIT: begin
                if (lat_cnt == LAT_LAST) begin
                    state_next = S_LATCH;
                end
            end
            S_LATCH: state_next = S_HOLD;
            S_HOLD: begin
                if (run && tick && (hold_cnt == HOLD_LAST)) begin
                    advance = 1'b1;
                end else if (!run && step) begin
                    advance = 1'b1;
                end
                if (advance) begin
                    state_next = S_FETCH;
                end
            end
            default: state_next = S_FETCH;
        endcase
    end

    // State register; reset restarts with a fetch of the first address.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Datapath: address, latency/hold counters and the latched display word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rom_addr   <= A_START;
            cur_addr   <= A_START;
            data       <= '0;
            data_valid <= 1'b0;
            busy       <= 1'b0;
            hold_cnt   <= '0;
            lat_cnt    <= '0;
        end else begin
            data_valid <= 1'b0;
            busy       <= (state_next == S_FETCH) || (state_next == S_WAIT);
            case (state)
                S_FETCH: lat_cnt <= '0;
                S_WAIT:  lat_cnt <= lat_cnt + LC_W'(1);
                S_LATCH: begin
                    data       <= rom_q;
                    cur_addr   <= rom_addr;
                    data_valid <= 1'b1;
                    hold_cnt   <= '0;
                end
                S_HOLD: begin
                    if (advance) begin
                        rom_addr <= addr_next;
                        hold_cnt <= '0;
                    end else if (run && tick) begin
                        hold_cnt <= hold_cnt + HC_W'(1);
                    end
                end
                default: lat_cnt <= '0;
            endcase
        end
    end

endmodule
